// File: rtl/kmeans_pkg.sv
// Shared widths, FSM encoding and component indexing for the k-means blocks.
package kmeans_pkg;

  localparam int COORD_W = 8;
  localparam int SUM_W   = 16;
  localparam int CNT_W   = 5;
  localparam int K       = 3;
  localparam int NCOMP   = 3 * K;

  // Centroid update sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    DIV   = 3'd2,
    STORE = 3'd3,
    FIN   = 3'd4
  } updState_e;

  typedef logic [3:0] compIdx_t;

  // Components are visited cluster by cluster, x then y then z.
  localparam compIdx_t COMP_0X = 4'd0;
  localparam compIdx_t COMP_0Y = 4'd1;
  localparam compIdx_t COMP_0Z = 4'd2;
  localparam compIdx_t COMP_1X = 4'd3;
  localparam compIdx_t COMP_1Y = 4'd4;
  localparam compIdx_t COMP_1Z = 4'd5;
  localparam compIdx_t COMP_2X = 4'd6;
  localparam compIdx_t COMP_2Y = 4'd7;
  localparam compIdx_t COMP_2Z = 4'd8;
  localparam compIdx_t LAST_COMP = COMP_2Z;

  // Cluster that owns a given component (selects which count is the divisor).
  function automatic logic [1:0] compCluster(input compIdx_t c);
    logic [1:0] cl;
    cl = 2'd2;
    case (c)
      COMP_0X, COMP_0Y, COMP_0Z: cl = 2'd0;
      COMP_1X, COMP_1Y, COMP_1Z: cl = 2'd1;
      default:                   cl = 2'd2;
    endcase
    return cl;
  endfunction

  // Clamp a 16-bit quotient into the 8-bit coordinate range.
  function automatic logic [COORD_W-1:0] satCoord(input logic [SUM_W-1:0] q);
    return (q > 16'd255) ? 8'hFF : q[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/serial_div16x5.sv
// Serial restoring divider: 16-bit dividend by 5-bit divisor, one quotient
// bit per cycle, MSB first. valid is high during the cycle that performs the
// final step, so quotient holds the complete result from the next cycle on.
module serial_div16x5
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             valid
);

  // The dividend register shifts out its MSB each step and takes the new
  // quotient bit in at the bottom, so after 16 steps it holds the quotient.
  logic [SUM_W-1:0] work_q, work_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dvsr_q, dvsr_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic             run_q, run_d;

  logic [CNT_W:0]   remShift;
  logic [CNT_W:0]   remSub;
  logic             fits;

  assign remShift = {rem_q, work_q[SUM_W-1]};
  assign fits     = (remShift >= {1'b0, dvsr_q});
  assign remSub   = remShift - {1'b0, dvsr_q};

  // Next-state logic: load on start, otherwise one restoring step while running.
  always_comb begin
    work_d   = work_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    bitCnt_d = bitCnt_q;
    run_d    = run_q;
    if (start) begin
      work_d   = dividend;
      rem_d    = '0;
      dvsr_d   = divisor;
      bitCnt_d = 4'd15;
      run_d    = 1'b1;
    end else if (run_q) begin
      work_d   = {work_q[SUM_W-2:0], fits};
      rem_d    = fits ? remSub[CNT_W-1:0] : remShift[CNT_W-1:0];
      bitCnt_d = bitCnt_q - 4'd1;
      if (bitCnt_q == 4'd0) begin
        run_d = 1'b0;
      end
    end
  end

  // Divider state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      bitCnt_q <= '0;
      run_q    <= 1'b0;
    end else begin
      work_q   <= work_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      bitCnt_q <= bitCnt_d;
      run_q    <= run_d;
    end
  end

  assign quotient = work_q;
  assign valid    = run_q && (bitCnt_q == 4'd0);

endmodule

// File: rtl/centroid_update.sv
// Recomputes the three k-means centroids (sum / count per component) from a
// frozen snapshot of the accumulators, sharing one serial divider across all
// nine components.
module centroid_update
  import kmeans_pkg::*;
#(
  parameter int          N       = 20,
  parameter logic [23:0] INIT_C0 = 24'h101010,
  parameter logic [23:0] INIT_C1 = 24'h808080,
  parameter logic [23:0] INIT_C2 = 24'hF0F0F0
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               update_centroids,
  input  logic [SUM_W-1:0]   sumx0,
  input  logic [SUM_W-1:0]   sumx1,
  input  logic [SUM_W-1:0]   sumx2,
  input  logic [SUM_W-1:0]   sumy0,
  input  logic [SUM_W-1:0]   sumy1,
  input  logic [SUM_W-1:0]   sumy2,
  input  logic [SUM_W-1:0]   sumz0,
  input  logic [SUM_W-1:0]   sumz1,
  input  logic [SUM_W-1:0]   sumz2,
  input  logic [CNT_W-1:0]   cnt0,
  input  logic [CNT_W-1:0]   cnt1,
  input  logic [CNT_W-1:0]   cnt2,
  output logic [COORD_W-1:0] c0x,
  output logic [COORD_W-1:0] c0y,
  output logic [COORD_W-1:0] c0z,
  output logic [COORD_W-1:0] c1x,
  output logic [COORD_W-1:0] c1y,
  output logic [COORD_W-1:0] c1z,
  output logic [COORD_W-1:0] c2x,
  output logic [COORD_W-1:0] c2y,
  output logic [COORD_W-1:0] c2z,
  output logic               busy,
  output logic               upd_done
);

  // A frame size that cannot be represented by the count inputs is a build error.
  if (N < 1 || N >= (1 << CNT_W)) begin : gBadN
    $error("centroid_update: N does not fit the count width");
  end

  // Reset centroids laid out in component order (element 0 = c0x).
  localparam logic [NCOMP-1:0][COORD_W-1:0] INIT_VEC = {
    INIT_C2[7:0], INIT_C2[15:8], INIT_C2[23:16],
    INIT_C1[7:0], INIT_C1[15:8], INIT_C1[23:16],
    INIT_C0[7:0], INIT_C0[15:8], INIT_C0[23:16]
  };

  logic [NCOMP-1:0][SUM_W-1:0]   sumIn;
  logic [K-1:0][CNT_W-1:0]       cntIn;
  logic [NCOMP-1:0][SUM_W-1:0]   sumSh_q;
  logic [K-1:0][CNT_W-1:0]       cntSh_q;
  logic [NCOMP-1:0][COORD_W-1:0] cent_q;

  updState_e state_q;
  compIdx_t  comp_q;
  logic      busy_q;
  logic      updDone_q;

  logic [SUM_W-1:0] selSum;
  logic [CNT_W-1:0] selCnt;
  logic             selZero;
  logic             divStart;
  logic [SUM_W-1:0] divQuot;
  logic             divValid;

  assign sumIn = {sumz2, sumy2, sumx2, sumz1, sumy1, sumx1, sumz0, sumy0, sumx0};
  assign cntIn = {cnt2, cnt1, cnt0};

  assign selSum   = sumSh_q[comp_q];
  assign selCnt   = cntSh_q[compCluster(comp_q)];
  assign selZero  = (selCnt == '0);
  assign divStart = (state_q == SEL) && !selZero;

  serial_div16x5 uDiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (divStart),
    .dividend (selSum),
    .divisor  (selCnt),
    .quotient (divQuot),
    .valid    (divValid)
  );

  // Track the accumulators while idle; the upstream FSM clears them on the
  // same edge as the update pulse, so the snapshot freezes on that cycle and
  // stays frozen for the whole update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sumSh_q <= '0;
      cntSh_q <= '0;
    end else if (state_q == IDLE && !update_centroids) begin
      sumSh_q <= sumIn;
      cntSh_q <= cntIn;
    end
  end

  // Sequencer: walks the nine components, skipping empty clusters, and
  // raises busy/upd_done as registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      comp_q    <= COMP_0X;
      busy_q    <= 1'b0;
      updDone_q <= 1'b0;
    end else begin
      updDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (update_centroids) begin
            state_q <= SEL;
            comp_q  <= COMP_0X;
            busy_q  <= 1'b1;
          end
        end
        SEL: begin
          if (selZero) begin
            if (comp_q == LAST_COMP) begin
              state_q   <= FIN;
              busy_q    <= 1'b0;
              updDone_q <= 1'b1;
            end else begin
              comp_q <= compIdx_t'(comp_q + 4'd1);
            end
          end else begin
            state_q <= DIV;
          end
        end
        DIV: begin
          if (divValid) begin
            state_q <= STORE;
          end
        end
        STORE: begin
          if (comp_q == LAST_COMP) begin
            state_q   <= FIN;
            busy_q    <= 1'b0;
            updDone_q <= 1'b1;
          end else begin
            comp_q  <= compIdx_t'(comp_q + 4'd1);
            state_q <= SEL;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Centroid registers change only when a finished quotient is stored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cent_q <= INIT_VEC;
    end else if (state_q == STORE) begin
      cent_q[comp_q] <= satCoord(divQuot);
    end
  end

  assign c0x      = cent_q[COMP_0X];
  assign c0y      = cent_q[COMP_0Y];
  assign c0z      = cent_q[COMP_0Z];
  assign c1x      = cent_q[COMP_1X];
  assign c1y      = cent_q[COMP_1Y];
  assign c1z      = cent_q[COMP_1Z];
  assign c2x      = cent_q[COMP_2X];
  assign c2y      = cent_q[COMP_2Y];
  assign c2z      = cent_q[COMP_2Z];
  assign busy     = busy_q;
  assign upd_done = updDone_q;

endmodule

// File: tb/tb_centroid_update.sv
// Directed bench for centroid_update: table of snapshot/result vectors plus
// hand-written sequences for a pulse while busy and reset mid-division.
module tb_centroid_update;

  logic clk;
  logic rst_n;
  logic update_centroids;
  logic [8:0][15:0] sumV;
  logic [2:0][4:0]  cntV;
  logic [7:0] c0x, c0y, c0z, c1x, c1y, c1z, c2x, c2y, c2z;
  logic [8:0][7:0] centV;
  logic busy;
  logic upd_done;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic [8:0][15:0] sum;
    logic [2:0][4:0]  cnt;
    logic [8:0][7:0]  expC;
    int               expLat;
  } vec_t;

  vec_t vecs[5];
  string compName[9] = '{"c0x", "c0y", "c0z", "c1x", "c1y", "c1z", "c2x", "c2y", "c2z"};

  centroid_update dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .update_centroids (update_centroids),
    .sumx0 (sumV[0]), .sumy0 (sumV[1]), .sumz0 (sumV[2]),
    .sumx1 (sumV[3]), .sumy1 (sumV[4]), .sumz1 (sumV[5]),
    .sumx2 (sumV[6]), .sumy2 (sumV[7]), .sumz2 (sumV[8]),
    .cnt0  (cntV[0]), .cnt1  (cntV[1]), .cnt2  (cntV[2]),
    .c0x (c0x), .c0y (c0y), .c0z (c0z),
    .c1x (c1x), .c1y (c1y), .c1z (c1z),
    .c2x (c2x), .c2y (c2y), .c2z (c2z),
    .busy     (busy),
    .upd_done (upd_done)
  );

  assign centV = {c2z, c2y, c2x, c1z, c1y, c1x, c0z, c0y, c0x};

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected reset centroids: 16 / 128 / 240 per cluster.
  function automatic logic [8:0][7:0] initExp();
    logic [8:0][7:0] e;
    for (int i = 0; i < 9; i++) begin
      e[i] = (i < 3) ? 8'd16 : ((i < 6) ? 8'd128 : 8'd240);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkCentroids(input string tag, input logic [8:0][7:0] expC);
    for (int i = 0; i < 9; i++) begin
      checkOutput({tag, "_", compName[i]}, int'(centV[i]), int'(expC[i]));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    update_centroids = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present the accumulators for two cycles, then pulse with them cleared.
  task automatic applyStimulus(input logic [8:0][15:0] s, input logic [2:0][4:0] c);
    @(negedge clk);
    sumV = s;
    cntV = c;
    repeat (2) @(negedge clk);
    update_centroids = 1'b1;
    sumV = '0;
    cntV = '0;
    @(posedge clk);
    #1 update_centroids = 1'b0;
  endtask

  // Called in cycle 1 after the pulse; returns the cycle upd_done is seen in
  // and the number of cycles busy disagreed with "high until done".
  task automatic waitDone(input int extraPulseAt, output int lat, output int busyBad);
    lat = -1;
    busyBad = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (upd_done) begin
        lat = c;
        if (busy) busyBad++;
        break;
      end
      if (!busy) busyBad++;
      if (c == extraPulseAt) update_centroids = 1'b1;
      @(posedge clk);
      #1 update_centroids = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int busyBad;
    int seen;
    logic [8:0][7:0] e;

    nCompared = 0;
    nMismatched = 0;
    rst_n = 1'b0;
    update_centroids = 1'b0;
    sumV = '0;
    cntV = '0;

    // V0: cluster 0 only, 1000/10
    vecs[0].sum = '0; vecs[0].cnt = '0;
    vecs[0].sum[0] = 16'd1000; vecs[0].sum[1] = 16'd1000; vecs[0].sum[2] = 16'd1000;
    vecs[0].cnt[0] = 5'd10;
    e = initExp(); e[0] = 8'd100; e[1] = 8'd100; e[2] = 8'd100;
    vecs[0].expC = e; vecs[0].expLat = 3 * 18 + 6 + 1;

    // V1: truncation and saturation in cluster 1 (cnt=20)
    vecs[1].sum = '0; vecs[1].cnt = '0;
    vecs[1].sum[3] = 16'd1019; vecs[1].sum[4] = 16'd5100; vecs[1].sum[5] = 16'd0;
    vecs[1].cnt[1] = 5'd20;
    e = initExp(); e[3] = 8'd50; e[4] = 8'd255; e[5] = 8'd0;
    vecs[1].expC = e; vecs[1].expLat = 3 + 54 + 3 + 1;

    // V2: count above N (31) in cluster 0, divide by 1 with saturation in cluster 2
    vecs[2].sum = '0; vecs[2].cnt = '0;
    vecs[2].sum[0] = 16'd7000; vecs[2].sum[1] = 16'd31; vecs[2].sum[2] = 16'd30;
    vecs[2].sum[6] = 16'd200;  vecs[2].sum[7] = 16'd31; vecs[2].sum[8] = 16'hFFFF;
    vecs[2].cnt[0] = 5'd31; vecs[2].cnt[2] = 5'd1;
    e = initExp(); e[0] = 8'd225; e[1] = 8'd1; e[2] = 8'd0;
    e[6] = 8'd200; e[7] = 8'd31; e[8] = 8'd255;
    vecs[2].expC = e; vecs[2].expLat = 54 + 3 + 54 + 1;

    // V3: all clusters populated
    vecs[3].sum[0] = 16'd700;  vecs[3].sum[1] = 16'd6;   vecs[3].sum[2] = 16'd1791;
    vecs[3].sum[3] = 16'd384;  vecs[3].sum[4] = 16'd100; vecs[3].sum[5] = 16'hFFFF;
    vecs[3].sum[6] = 16'd4000; vecs[3].sum[7] = 16'd19;  vecs[3].sum[8] = 16'd2560;
    vecs[3].cnt[0] = 5'd7; vecs[3].cnt[1] = 5'd3; vecs[3].cnt[2] = 5'd20;
    e[0] = 8'd100; e[1] = 8'd0;  e[2] = 8'd255;
    e[3] = 8'd128; e[4] = 8'd33; e[5] = 8'd255;
    e[6] = 8'd200; e[7] = 8'd0;  e[8] = 8'd128;
    vecs[3].expC = e; vecs[3].expLat = 163;

    // V4: all counts zero, sums nonzero
    vecs[4].sum = '0; vecs[4].cnt = '0;
    vecs[4].sum[0] = 16'd500; vecs[4].sum[4] = 16'd900;
    vecs[4].expC = initExp(); vecs[4].expLat = 10;

    doReset();
    checkCentroids("reset", initExp());
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_upd_done", int'(upd_done), 0);

    for (int v = 0; v < 5; v++) begin
      doReset();
      applyStimulus(vecs[v].sum, vecs[v].cnt);
      waitDone(0, lat, busyBad);
      checkOutput($sformatf("v%0d_latency", v), lat, vecs[v].expLat);
      checkOutput($sformatf("v%0d_busy_window", v), busyBad, 0);
      checkCentroids($sformatf("v%0d", v), vecs[v].expC);
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_pulse_width", v), int'(upd_done), 0);
      checkOutput($sformatf("v%0d_busy_after", v), int'(busy), 0);
    end

    // Second pulse while dividing comp 0x is ignored and not queued.
    doReset();
    applyStimulus(vecs[0].sum, vecs[0].cnt);
    waitDone(10, lat, busyBad);
    checkOutput("repulse_latency", lat, vecs[0].expLat);
    checkOutput("repulse_busy_window", busyBad, 0);
    checkCentroids("repulse", vecs[0].expC);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy || upd_done) seen++;
    end
    checkOutput("repulse_no_requeue", seen, 0);

    // Reset during the division of comp 0y: c0x already written, c0y not yet.
    doReset();
    applyStimulus(vecs[0].sum, vecs[0].cnt);
    repeat (24) @(posedge clk);
    @(negedge clk);
    checkOutput("middiv_c0x_written", int'(c0x), 100);
    checkOutput("middiv_c0y_pending", int'(c0y), 16);
    checkOutput("middiv_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkCentroids("midreset", initExp());
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_upd_done", int'(upd_done), 0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (upd_done || busy) seen++;
    end
    checkOutput("midreset_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
